generic_fifo_sc_prog: RTL and testbench

GENERIC_FIFO_SC_PROG -- requirements
Module: generic_fifo_sc_prog

---
 rtl/generic_fifo_sc_prog.sv | 217 +++++++++++++++++++++
 tb/tb_generic_fifo_sc_prog.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_fifo_sc_prog.sv
`default_nettype none
// ============================================================================
// Module   : generic_fifo_sc_prog
// Purpose  : Single-clock FIFO with programmable almost-full/almost-empty
//            thresholds, coarse quarter-level indication, exact occupancy
//            count and sticky overflow/underflow error flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   dw       data width in bits
//   aw       address width; depth D = 2**aw words
//   n        almost-full/almost-empty threshold in words (1 <= n < D/2)
// Ports
//   clk        in   clock, everything on its rising edge
//   rst        in   synchronous reset, active low
//   clr        in   synchronous clear, active high (memory untouched)
//   din[dw]    in   write data
//   we, re     in   write / read requests
//   dout[dw]   out  read data
//   full       out  count == D
//   empty      out  count == 0
//   full_n     out  almost full,  count >= D-n
//   empty_n    out  almost empty, count <= n
//   level[2]   out  occupancy quarter (00 <D/4, 01 <D/2, 10 <3D/4, 11 else)
//   count[aw+1] out exact occupancy 0..D
//   overflow   out  sticky: write attempted while full
//   underflow  out  sticky: read attempted while empty
// Build option
//   GENERIC_FIFO_FWFT_EN  when defined, dout shows the head word whenever the
//                         FIFO is not empty (first-word-fall-through). When
//                         undefined, dout is registered and updates the cycle
//                         after an accepted read.
// ============================================================================
module generic_fifo_sc_prog #(
  parameter int dw = 8,
  parameter int aw = 8,
  parameter int n  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [dw-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [dw-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          full_n,
  output logic          empty_n,
  output logic [1:0]    level,
  output logic [aw:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned C_DEPTH   = 1 << aw;
  localparam logic [aw:0] C_FULL    = (aw+1)'(C_DEPTH);
  localparam logic [aw:0] C_Q1      = (aw+1)'(C_DEPTH / 4);
  localparam logic [aw:0] C_Q2      = (aw+1)'(C_DEPTH / 2);
  localparam logic [aw:0] C_Q3      = (aw+1)'((3 * C_DEPTH) / 4);
  localparam logic [aw:0] C_AF      = (aw+1)'(C_DEPTH - n);
  localparam logic [aw:0] C_AE      = (aw+1)'(n);
  localparam logic [aw:0] C_CNT_ONE = (aw+1)'(1);
  localparam logic [aw-1:0] C_PTR_ONE = aw'(1);

  // Storage: plain array, one write port, one read port, never reset.
  logic [dw-1:0] mem [C_DEPTH];

  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [aw:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          full_n_q, full_n_d;
  logic          empty_n_q, empty_n_d;
  logic [1:0]    level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          w_we_acc;
  logic          w_re_acc;

  // Acceptance is judged on the registered flags, so a write into a full
  // FIFO stays dropped even when a read frees a slot in the same cycle.
  // clr blocks both requests outright.
  assign w_we_acc = we & ~full_q  & ~clr;
  assign w_re_acc = re & ~empty_q & ~clr;

  // --------------------------------------------------------------------------
  // Pointer, count and error-flag next state
  // --------------------------------------------------------------------------
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wp_d        = '0;
      rp_d        = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_we_acc) wp_d = wp_q + C_PTR_ONE;
      if (w_re_acc) rp_d = rp_q + C_PTR_ONE;

      // Simultaneous accepted read and write leave the count unchanged.
      case ({w_we_acc, w_re_acc})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase

      if (we && full_q)  overflow_d  = 1'b1;
      if (re && empty_q) underflow_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy flags derived from the next count, so they register in step
  // with the count itself. A clear forces count_d to zero, which yields the
  // reset values of every flag without a separate path.
  // --------------------------------------------------------------------------
  always_comb begin
    full_d    = (count_d == C_FULL);
    empty_d   = (count_d == '0);
    full_n_d  = (count_d >= C_AF);
    empty_n_d = (count_d <= C_AE);

    if (count_d < C_Q1) begin
      level_d = 2'b00;
    end else if (count_d < C_Q2) begin
      level_d = 2'b01;
    end else if (count_d < C_Q3) begin
      level_d = 2'b10;
    end else begin
      level_d = 2'b11;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      full_n_q    <= 1'b0;
      empty_n_q   <= 1'b1;
      level_q     <= 2'b00;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      full_n_q    <= full_n_d;
      empty_n_q   <= empty_n_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write. Gated by rst so a write presented during reset is lost.
  always_ff @(posedge clk) begin
    if (rst && w_we_acc) begin
      mem[wp_q] <= din;
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
`ifdef GENERIC_FIFO_FWFT_EN
  // Head word is presented combinationally from the read pointer. While
  // empty the output is parked at zero so it stays stable.
  assign dout = empty_q ? '0 : mem[rp_q];
`else
  logic [dw-1:0] dout_q, dout_d;

  // Registered read: the popped word appears the cycle after the read and
  // holds until the next accepted read. A clear leaves it untouched.
  always_comb begin
    dout_d = dout_q;
    if (w_re_acc) dout_d = mem[rp_q];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`endif

  assign full      = full_q;
  assign empty     = empty_q;
  assign full_n    = full_n_q;
  assign empty_n   = empty_n_q;
  assign level     = level_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_generic_fifo_sc_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_generic_fifo_sc_prog
// Purpose  : Self-checking bench for generic_fifo_sc_prog (dw=8, aw=4, n=4).
//            A queue-based reference model predicts occupancy, flags, error
//            bits and read data; directed scenarios plus a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generic_fifo_sc_prog;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, empty, full_n, empty_n, overflow, underflow;
  logic [1:0]    level;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_ufl = 1'b0;
  logic [7:0] m_dout = 8'h00;

  generic_fifo_sc_prog #(.dw(DW), .aw(AW), .n(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
    .dout(dout), .full(full), .empty(empty), .full_n(full_n),
    .empty_n(empty_n), .level(level), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  wire [12:0] dut_status = {count, full, empty, full_n, empty_n, level, overflow, underflow};

  // Expected status straight from the occupancy rules.
  function automatic logic [12:0] exp_status();
    int c;
    logic [1:0] lv;
    c  = q.size();
    lv = (c >= 12) ? 2'd3 : 2'(c / 4);
    return {5'(c), (c == D), (c == 0), (c >= D - N), (c <= N), lv, m_ovf, m_ufl};
  endfunction

  function automatic bit dout_checkable();
`ifdef GENERIC_FIFO_FWFT_EN
    return q.size() != 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_dout();
`ifdef GENERIC_FIFO_FWFT_EN
    return q[0];
`else
    return m_dout;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle.
  task automatic step(input bit r, input bit c, input bit w, input bit rd, input logic [7:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    rst = r; clr = c; we = w; re = rd; din = d;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_ovf = 1'b0; m_ufl = 1'b0; m_dout = 8'h00;
    end else if (c) begin
      q.delete(); m_ovf = 1'b0; m_ufl = 1'b0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_ufl = 1'b1;
      if (rd && !was_empty) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 1, 8'hAA);
      n_checks++;
      if (dut_status !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL reset status: got %h want %h", dut_status, 13'h0050);
      end
`ifndef GENERIC_FIFO_FWFT_EN
      n_checks++;
      if (dout !== 8'h00) begin
        n_fail++; $display("FAIL reset dout: got %h want 00", dout);
      end
`endif
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      step(1, 0, 1, 0, 8'(i));
      n_checks++;
      if (dut_status !== exp_status()) begin
        n_fail++; $display("FAIL fill[%0d] status: got %h want %h", i, dut_status, exp_status());
      end
      if (i == 11) begin
        n_checks++;
        if (full_n !== 1'b1 || full !== 1'b0) begin
          n_fail++; $display("FAIL fill almost_full: got full_n=%b full=%b want 1 0", full_n, full);
        end
      end
    end
    n_checks++;
    if (count !== 5'd16 || full !== 1'b1 || level !== 2'b11) begin
      n_fail++; $display("FAIL fill full: got count=%0d full=%b level=%b want 16 1 11", count, full, level);
    end
    step(1, 0, 1, 0, 8'hFF);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL fill overflow: got ovf=%b count=%0d want 1 16", overflow, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      step(1, 0, 0, 1, 8'h00);
      n_checks++;
      if (dut_status !== exp_status()) begin
        n_fail++; $display("FAIL drain[%0d] status: got %h want %h", i, dut_status, exp_status());
      end
`ifndef GENERIC_FIFO_FWFT_EN
      n_checks++;
      if (dout !== 8'(i)) begin
        n_fail++; $display("FAIL drain[%0d] dout: got %h want %h", i, dout, 8'(i));
      end
`endif
    end
    step(1, 0, 0, 1, 8'h00);
    n_checks++;
    if (underflow !== 1'b1 || empty !== 1'b1 || count !== 5'd0) begin
      n_fail++; $display("FAIL drain underflow: got ufl=%b empty=%b count=%0d want 1 1 0", underflow, empty, count);
    end
`ifndef GENERIC_FIFO_FWFT_EN
    n_checks++;
    if (dout !== 8'h0F) begin
      n_fail++; $display("FAIL drain hold: got %h want 0f", dout);
    end
`endif
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_list[$];
    step(1, 1, 0, 0, 8'h00);
    n_checks++;
    if (dut_status !== exp_status()) begin
      n_fail++; $display("FAIL simul clear: got %h want %h", dut_status, exp_status());
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0, 8'(8'h10 + i));
      exp_list.push_back(8'(8'h10 + i));
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 1, 8'(8'h20 + i));
      exp_list.push_back(8'(8'h20 + i));
      n_checks++;
      if (count !== 5'd5 || dut_status !== exp_status()) begin
        n_fail++; $display("FAIL simul[%0d] status: got %h want %h", i, dut_status, exp_status());
      end
    end
    // The 10 simultaneous reads consumed the first 10 words of the list.
    for (int i = 0; i < 10; i++) void'(exp_list.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 8'h00);
`ifndef GENERIC_FIFO_FWFT_EN
      n_checks++;
      if (dout !== exp_list[i]) begin
        n_fail++; $display("FAIL simul read[%0d]: got %h want %h", i, dout, exp_list[i]);
      end
`endif
      n_checks++;
      if (dut_status !== exp_status()) begin
        n_fail++; $display("FAIL simul read[%0d] status: got %h want %h", i, dut_status, exp_status());
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < D + 1; i++) step(1, 0, 1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 8'h00);
    n_checks++;
    if (count !== 5'd7 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL clear pre: got count=%0d ovf=%b want 7 1", count, overflow);
    end
    step(1, 1, 1, 0, 8'h55);
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || dut_status !== exp_status()) begin
      n_fail++; $display("FAIL clear post: got %h want %h", dut_status, exp_status());
    end
    step(1, 0, 1, 0, 8'h66);
    step(1, 0, 0, 1, 8'h00);
    n_checks++;
    if (count !== 5'd0 || dut_status !== exp_status()) begin
      n_fail++; $display("FAIL clear readback status: got %h want %h", dut_status, exp_status());
    end
`ifndef GENERIC_FIFO_FWFT_EN
    n_checks++;
    if (dout !== 8'h66) begin
      n_fail++; $display("FAIL clear readback: got %h want 66", dout);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 8'(8'h40 + i));
    n_checks++;
    if (count !== 5'd9) begin
      n_fail++; $display("FAIL rstmid pre: got count=%0d want 9", count);
    end
    step(0, 0, 1, 1, 8'h77);
    n_checks++;
    if (dut_status !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rstmid status: got %h want %h", dut_status, 13'h0050);
    end
`ifndef GENERIC_FIFO_FWFT_EN
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++; $display("FAIL rstmid dout: got %h want 00", dout);
    end
`endif
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 8'h00);
`ifndef GENERIC_FIFO_FWFT_EN
      n_checks++;
      if (dout !== 8'(8'h80 + i)) begin
        n_fail++; $display("FAIL rstmid read[%0d]: got %h want %h", i, dout, 8'(8'h80 + i));
      end
`endif
    end
    n_checks++;
    if (empty !== 1'b1 || dut_status !== exp_status()) begin
      n_fail++; $display("FAIL rstmid end: got %h want %h", dut_status, exp_status());
    end
  endtask

  task automatic test_random();
    bit r, c, w, rd;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 149) != 0);
      c  = ($urandom_range(0, 59) == 0);
      // Alternate write-heavy and read-heavy phases to reach both ends.
      if (((i / 75) % 2) == 0) begin
        w  = ($urandom_range(0, 9) < 7);
        rd = ($urandom_range(0, 9) < 3);
      end else begin
        w  = ($urandom_range(0, 9) < 3);
        rd = ($urandom_range(0, 9) < 7);
      end
      step(r, c, w, rd, 8'($urandom));
      n_checks++;
      if (dut_status !== exp_status()) begin
        n_fail++; $display("FAIL random[%0d] status: got %h want %h", i, dut_status, exp_status());
      end
      if (dout_checkable()) begin
        n_checks++;
        if (dout !== exp_dout()) begin
          n_fail++; $display("FAIL random[%0d] dout: got %h want %h", i, dout, exp_dout());
        end
      end
    end
  endtask

`ifdef GENERIC_FIFO_FWFT_EN
  task automatic test_fwft();
    step(1, 1, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'hA5);
    step(1, 0, 0, 0, 8'h00);
    n_checks++;
    if (empty !== 1'b0 || dout !== 8'hA5) begin
      n_fail++; $display("FAIL fwft head: got empty=%b dout=%h want 0 a5", empty, dout);
    end
    step(1, 0, 0, 1, 8'h00);
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL fwft pop: got empty=%b want 1", empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_clear();
    test_reset_mid();
`ifdef GENERIC_FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
